// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller.
// Runs a track phase with the front end sampling, then resolves one bit per
// SETTLE+1 cycles from MSB to LSB using the external comparator, and publishes
// the final code with a one-cycle done pulse. All outputs are registered.
module sar_adc_ctrl #(
  parameter int WIDTH      = 8,
  parameter int SAMPLE_CYC = 4,
  parameter int SETTLE     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cmp_in,
  output logic             sample,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRACK,
    ST_SETTLE,
    ST_DECIDE,
    ST_DONE
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [3:0]       TOP = 4'(WIDTH - 1);

  state_t           state_reg;
  logic [7:0]       cnt_reg;
  logic [3:0]       bit_reg;
  logic             sample_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] dac_reg;
  logic [WIDTH-1:0] result_reg;

  logic [WIDTH-1:0] kept_code;
  logic [WIDTH-1:0] next_trial;

  // Comparator decision for the bit under test, and the trial code for the next lower bit.
  always_comb begin
    kept_code  = cmp_in ? dac_reg : (dac_reg & ~(ONE << bit_reg));
    next_trial = kept_code | (ONE << (bit_reg - 4'd1));
  end

  // Conversion FSM with registered outputs; abort from any busy state returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= 8'd0;
      bit_reg    <= TOP;
      sample_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      dac_reg    <= '0;
      result_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg != ST_IDLE && abort) begin
        state_reg  <= ST_IDLE;
        cnt_reg    <= 8'd0;
        bit_reg    <= TOP;
        sample_reg <= 1'b0;
        busy_reg   <= 1'b0;
        dac_reg    <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            // abort wins over a simultaneous start
            if (start && !abort) begin
              state_reg  <= ST_TRACK;
              sample_reg <= 1'b1;
              busy_reg   <= 1'b1;
              dac_reg    <= '0;
              cnt_reg    <= 8'(SAMPLE_CYC - 1);
              bit_reg    <= TOP;
            end
          end
          ST_TRACK: begin
            if (cnt_reg == 8'd0) begin
              sample_reg <= 1'b0;
              dac_reg    <= ONE << TOP;
              bit_reg    <= TOP;
              if (SETTLE == 0) begin
                state_reg <= ST_DECIDE;
              end else begin
                state_reg <= ST_SETTLE;
                cnt_reg   <= 8'(SETTLE - 1);
              end
            end else begin
              cnt_reg <= cnt_reg - 8'd1;
            end
          end
          ST_SETTLE: begin
            if (cnt_reg == 8'd0) begin
              state_reg <= ST_DECIDE;
            end else begin
              cnt_reg <= cnt_reg - 8'd1;
            end
          end
          ST_DECIDE: begin
            if (bit_reg == 4'd0) begin
              result_reg <= kept_code;
              dac_reg    <= kept_code;
              done_reg   <= 1'b1;
              state_reg  <= ST_DONE;
            end else begin
              dac_reg <= next_trial;
              bit_reg <= bit_reg - 4'd1;
              if (SETTLE == 0) begin
                state_reg <= ST_DECIDE;
              end else begin
                state_reg <= ST_SETTLE;
                cnt_reg   <= 8'(SETTLE - 1);
              end
            end
          end
          ST_DONE: begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            dac_reg   <= '0;
            bit_reg   <= TOP;
          end
          default: begin
            state_reg  <= ST_IDLE;
            busy_reg   <= 1'b0;
            sample_reg <= 1'b0;
            dac_reg    <= '0;
            bit_reg    <= TOP;
          end
        endcase
      end
    end
  end

  assign sample   = sample_reg;
  assign dac_code = dac_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign result   = result_reg;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: a default 8-bit instance driven from a vector table
// plus corner sequences, and a 4-bit SETTLE=0 instance.
// Cycle k after the start-accepting edge E0 is the interval following edge E(k-1);
// done "at cycle N" is therefore first seen just after edge E(N-1).
module tb_sar_adc_ctrl;

  localparam int N8 = 4 + 8 * (2 + 1) + 1;   // 29
  localparam int N4 = 1 + 4 * (0 + 1) + 1;   // 6

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       cmp_in;
  logic       sample;
  logic [7:0] dac_code;
  logic       busy;
  logic       done;
  logic [7:0] result;

  logic       start4 = 1'b0;
  logic       cmp4;
  logic       sample4;
  logic [3:0] dac4;
  logic       busy4;
  logic       done4;
  logic [3:0] result4;

  logic [7:0] vin_code = 8'h00;
  int         cmp_mode = 0;   // 0: compare, 1: stuck 1, 2: stuck 0
  logic [3:0] vin4 = 4'h0;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [7:0] res;
    int         lat;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [7:0] vin;
    int         mode;
    logic [7:0] exp_res;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  assign cmp_in = (cmp_mode == 1) ? 1'b1 : (cmp_mode == 2) ? 1'b0 : (vin_code >= dac_code);
  assign cmp4   = (vin4 >= dac4);

  sar_adc_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cmp_in(cmp_in),
    .sample(sample), .dac_code(dac_code), .busy(busy), .done(done), .result(result)
  );

  sar_adc_ctrl #(.WIDTH(4), .SAMPLE_CYC(1), .SETTLE(0)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .abort(1'b0), .cmp_in(cmp4),
    .sample(sample4), .dac_code(dac4), .busy(busy4), .done(done4), .result(result4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full conversion on the default instance, with dac step and latency checks.
  task automatic convert(input logic [7:0] vin, input int mode, input logic [7:0] exp_res);
    logic [7:0] steps[$];
    logic [7:0] acc;
    logic [7:0] trial;
    logic [7:0] prev;
    logic [7:0] s;
    exp_t       e;
    int         edges;
    vin_code = vin;
    cmp_mode = mode;
    acc = 8'h00;
    for (int b = 7; b >= 0; b--) begin
      trial = acc | (8'h01 << b);
      steps.push_back(trial);
      if (mode == 1 || (mode == 0 && vin >= trial)) acc = trial;
    end
    e.res = exp_res;
    e.lat = N8 - 1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_sample", 32'(sample), 32'd1);
    edges = 0;
    prev = 8'h00;
    while (edges < 100 && !done) begin
      tick();
      edges++;
      if (!done && dac_code != prev) begin
        if (steps.size() > 0) begin
          s = steps.pop_front();
          if (mode == 0) chk("dac_step", 32'(dac_code), 32'(s));
        end else begin
          chk("dac_extra_step", 32'(dac_code), 32'(prev));
        end
      end
      prev = dac_code;
    end
    chk("done_seen", 32'(done), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("latency", 32'(edges), 32'(e.lat));
      chk("result", 32'(result), 32'(e.res));
    end
    chk("busy_in_done", 32'(busy), 32'd1);
    tick();
    chk("done_pulse_1cyc", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    $display("conv vin=0x%02h mode=%0d result=0x%02h edges=%0d", vin, mode, result, edges);
  endtask

  initial begin
    int edges;
    int ndone;
    int last_done;
    int gaps[$];

    vecs[0] = '{8'hA5, 0, 8'hA5};
    vecs[1] = '{8'h00, 1, 8'hFF};
    vecs[2] = '{8'hFF, 2, 8'h00};
    vecs[3] = '{8'h00, 0, 8'h00};
    vecs[4] = '{8'hFF, 0, 8'hFF};
    vecs[5] = '{8'h80, 0, 8'h80};
    vecs[6] = '{8'h7F, 0, 8'h7F};
    vecs[7] = '{8'hA5, 0, 8'hA5};

    // reset state, without any clock edge having occurred
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_dac", 32'(dac_code), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("idle_after_rst", 32'(busy), 32'd0);

    for (int i = 0; i < 8; i++) convert(vecs[i].vin, vecs[i].mode, vecs[i].exp_res);

    // abort at cycle 10 -> idle at cycle 11, result keeps 0xA5, no done
    vin_code = 8'h3C;
    cmp_mode = 0;
    @(negedge clk);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sample", 32'(sample), 32'd0);
    chk("abort_dac", 32'(dac_code), 32'd0);
    chk("abort_result", 32'(result), 32'hA5);
    ndone = 0;
    repeat (40) begin
      tick();
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    $display("abort at cycle 10: busy=%0d result=0x%02h", busy, result);

    // abort and start together in IDLE: abort wins
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_vs_start", 32'(busy), 32'd0);
    tick();
    chk("abort_vs_start2", 32'(busy), 32'd0);
    $display("abort+start in idle: busy=%0d", busy);

    // asynchronous reset between edges mid-conversion
    @(negedge clk);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_dac", 32'(dac_code), 32'd0);
    chk("arst_result", 32'(result), 32'd0);
    chk("arst_sample", 32'(sample), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    chk("no_start_after_rst", 32'(busy), 32'd0);
    $display("async reset mid-conversion: result=0x%02h busy=%0d", result, busy);
    convert(8'h3C, 0, 8'h3C);

    // repeated start pulses while busy -> exactly one done
    vin_code = 8'h5A;
    @(negedge clk);
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 60; k++) begin
      start = (k < 24) && (k % 2 == 0);
      tick();
      if (done) ndone++;
    end
    start = 1'b0;
    chk("pulsed_start_one_done", 32'(ndone), 32'd1);
    chk("pulsed_start_result", 32'(result), 32'h5A);
    $display("start pulsed while busy: dones=%0d", ndone);

    // start held high -> back-to-back conversions, one IDLE cycle between
    @(negedge clk);
    start = 1'b1;
    ndone = 0;
    last_done = -1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (done) begin
        ndone++;
        if (last_done >= 0) gaps.push_back(k - last_done);
        last_done = k;
      end else if (last_done >= 0 && k == last_done + 1) begin
        chk("b2b_idle_gap", 32'(busy), 32'd0);
      end
    end
    start = 1'b0;
    chk("b2b_dones", 32'(ndone >= 3), 32'd1);
    foreach (gaps[g]) chk("b2b_spacing", 32'(gaps[g]), 32'(N8 + 1));
    $display("start held: dones=%0d", ndone);
    edges = 0;
    while (busy && edges < 100) begin
      tick();
      edges++;
    end
    chk("b2b_drain", 32'(busy), 32'd0);

    // 4-bit, SETTLE=0, SAMPLE_CYC=1 instance
    for (int v = 0; v < 2; v++) begin
      vin4 = (v == 0) ? 4'h9 : 4'h0;
      @(negedge clk);
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      edges = 0;
      while (edges < 50 && !done4) begin
        tick();
        edges++;
      end
      chk("w4_done", 32'(done4), 32'd1);
      chk("w4_latency", 32'(edges), 32'(N4 - 1));
      chk("w4_result", 32'(result4), 32'(vin4));
      $display("w4 conv vin=0x%0h result=0x%0h edges=%0d", vin4, result4, edges);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
